core_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the core.
- Drives the 3-bit `state` bus consumed by the fetch, decode, exec and memory stages, and owns the architectural PC.
- Stalls EX until the exec stage reports `data_ready` (ALU or FPU result) and stalls MEM until the data memory handshake completes.
- Commits PC and the retire count in WB.

---
 rtl/core_sequencer.sv | 121 ++++++++++++
 tb/tb_core_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer that owns the architectural PC and retire count.
// Optional EX watchdog fault is enabled by defining CORE_SEQ_EX_TIMEOUT_EN.
module core_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned EX_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        imem_ready,
  input  logic        ex_data_ready,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        dmem_ready,
  input  logic        ex_branch,
  input  logic [31:0] ex_branch_addr,
  output logic [2:0]  state,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        wb_en,
  output logic        busy,
  output logic [31:0] retired,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_IDLE = 3'd7
  } state_e;

  localparam int CNT_W = (EX_TIMEOUT < 2) ? 2 : $clog2(EX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      retired_q;
  logic [CNT_W-1:0] ex_cnt_q;
  logic             halt_q;
  logic             mem_access;
  logic             ex_done;
  logic             mem_done;
  logic             ex_tmo;
  logic             start_ok;

  assign mem_access = ex_mem_read | ex_mem_write;
  // data_ready seen in the first EX cycle belongs to the previous instruction
  assign ex_done    = ex_data_ready && (ex_cnt_q != '0);
  assign mem_done   = !mem_access || dmem_ready;
  assign pc_d       = ex_branch ? (ex_branch_addr & ~32'h3) : pc_q + 32'd4;

`ifdef CORE_SEQ_EX_TIMEOUT_EN
  logic fault_q;

  // fires on the EX cycle whose count increment would reach EX_TIMEOUT
  assign ex_tmo   = (state_q == S_EX) && !ex_data_ready &&
                    ((32'(ex_cnt_q) + 32'd1) >= 32'(EX_TIMEOUT));
  assign start_ok = start && !fault_q;
  assign fault    = fault_q;

  always_ff @(posedge clk) begin
    if (rst)         fault_q <= 1'b0;
    else if (ex_tmo) fault_q <= 1'b1;
  end
`else
  assign ex_tmo   = 1'b0;
  assign start_ok = start;
  assign fault    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      ex_cnt_q  <= '0;
      halt_q    <= 1'b0;
    end else begin
      if ((state_q != S_IDLE) && halt_req) halt_q <= 1'b1;
      unique case (state_q)
        S_IDLE: if (start_ok) begin
          state_q <= S_IF;
          halt_q  <= 1'b0;
        end
        S_IF: if (imem_ready) state_q <= S_ID;
        S_ID: begin
          state_q  <= S_EX;
          ex_cnt_q <= '0;
        end
        S_EX: begin
          if (ex_cnt_q != CNT_MAX) ex_cnt_q <= ex_cnt_q + CNT_ONE;
          if (ex_tmo)       state_q <= S_IDLE;
          else if (ex_done) state_q <= S_MEM;
        end
        S_MEM: if (mem_done) state_q <= S_WB;
        S_WB: begin
          pc_q      <= pc_d;
          retired_q <= retired_q + 32'd1;
          state_q   <= (halt_req || halt_q) ? S_IDLE : S_IF;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state    = state_q;
  assign pc       = pc_q;
  assign retired  = retired_q;
  assign imem_req = (state_q == S_IF);
  assign dmem_req = (state_q == S_MEM) && mem_access;
  assign wb_en    = (state_q == S_WB);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: per-instruction plans expanded into an expected cycle timeline.
module tb_core_sequencer;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_MEM = 3'd3,
                         ST_WB = 3'd4, ST_IDLE = 3'd7;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, imem_ready, ex_data_ready;
  logic        ex_mem_read, ex_mem_write, dmem_ready, ex_branch;
  logic [31:0] ex_branch_addr;
  logic [2:0]  state;
  logic [31:0] pc, retired;
  logic        imem_req, dmem_req, wb_en, busy, fault;

  core_sequencer #(.RESET_PC(RST_PC), .EX_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_ready(imem_ready), .ex_data_ready(ex_data_ready),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .dmem_ready(dmem_ready), .ex_branch(ex_branch), .ex_branch_addr(ex_branch_addr),
    .state(state), .pc(pc), .imem_req(imem_req), .dmem_req(dmem_req),
    .wb_en(wb_en), .busy(busy), .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  // one expected cycle: inputs to drive plus the architectural state the DUT should show
  typedef struct {
    logic [2:0]  st;
    logic        start, halt, imr, exr, mrd, mwr, dmr, br;
    logic [31:0] ba, pc, ret;
  } ent_t;

  typedef struct {
    int          if_w;
    logic        ex0;
    int          ex_s;
    logic        mrd, mwr;
    int          dm_w;
    logic        br;
    logic [31:0] ba;
    int          halt_at;
  } plan_t;

  ent_t        q[$];
  logic [31:0] m_pc, m_ret;
  logic        m_idle;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [2:0] st);
    ent_t e;
    e.st = st; e.start = 1'b0; e.halt = 1'b0;
    e.imr = 1'($urandom); e.exr = 1'($urandom); e.mrd = 1'($urandom);
    e.mwr = 1'($urandom); e.dmr = 1'($urandom); e.br = 1'($urandom);
    e.ba = $urandom; e.pc = m_pc; e.ret = m_ret;
    return e;
  endfunction

  function automatic plan_t mkp(input int if_w, input logic ex0, input int ex_s,
                                input logic mrd, input logic mwr, input int dm_w,
                                input logic br, input logic [31:0] ba, input int halt_at);
    plan_t p;
    p.if_w = if_w; p.ex0 = ex0; p.ex_s = ex_s; p.mrd = mrd; p.mwr = mwr;
    p.dm_w = dm_w; p.br = br; p.ba = ba; p.halt_at = halt_at;
    return p;
  endfunction

  // expand one instruction into its expected cycles and commit it in the model
  task automatic gen(input plan_t p);
    ent_t e;
    int   n0, gap, nm;
    if (m_idle) begin
      gap = int'($urandom_range(0, 2));
      for (int i = 0; i < gap; i++) begin
        e = mk(ST_IDLE); e.halt = 1'($urandom); q.push_back(e);
      end
      e = mk(ST_IDLE); e.start = 1'b1; e.halt = 1'($urandom); q.push_back(e);
      m_idle = 1'b0;
    end
    n0 = q.size();
    for (int i = 0; i <= p.if_w; i++) begin
      e = mk(ST_IF); e.imr = (i == p.if_w); q.push_back(e);
    end
    q.push_back(mk(ST_ID));
    for (int k = 0; k < p.ex_s + 2; k++) begin
      e = mk(ST_EX); e.exr = (k == 0) ? p.ex0 : (k == p.ex_s + 1); q.push_back(e);
    end
    nm = (p.mrd || p.mwr) ? p.dm_w + 1 : 1;
    for (int k = 0; k < nm; k++) begin
      e = mk(ST_MEM); e.mrd = p.mrd; e.mwr = p.mwr;
      if (p.mrd || p.mwr) e.dmr = (k == p.dm_w);
      q.push_back(e);
    end
    e = mk(ST_WB); e.br = p.br; e.ba = p.ba; q.push_back(e);
    if (p.halt_at >= 0) q[n0 + p.halt_at % (q.size() - n0)].halt = 1'b1;
    m_pc   = p.br ? {p.ba[31:2], 2'b00} : m_pc + 32'd4;
    m_ret  = m_ret + 32'd1;
    m_idle = (p.halt_at >= 0);
  endtask

  // called just after a posedge; drives the cycle, checks at negedge, returns after next posedge
  task automatic step(input ent_t e);
    start = e.start; halt_req = e.halt; imem_ready = e.imr; ex_data_ready = e.exr;
    ex_mem_read = e.mrd; ex_mem_write = e.mwr; dmem_ready = e.dmr;
    ex_branch = e.br; ex_branch_addr = e.ba;
    @(negedge clk);
    chk("state", 32'(state), 32'(e.st));
    chk("pc", pc, e.pc);
    chk("retired", retired, e.ret);
    chk("imem_req", 32'(imem_req), 32'(e.st == ST_IF));
    chk("dmem_req", 32'(dmem_req), 32'((e.st == ST_MEM) && (e.mrd || e.mwr)));
    chk("wb_en", 32'(wb_en), 32'(e.st == ST_WB));
    chk("busy", 32'(busy), 32'(e.st != ST_IDLE));
    chk("fault", 32'(fault), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) step(q.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    plan_t p;
    int    sel, idx;
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; imem_ready = 1'b0; ex_data_ready = 1'b0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; dmem_ready = 1'b0; ex_branch = 1'b0;
    ex_branch_addr = '0;
    m_pc = RST_PC; m_ret = '0; m_idle = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_pc", pc, RST_PC);
    chk("rst_retired", retired, 32'd0);
    chk("rst_strobes", 32'({imem_req, dmem_req, wb_en, busy, fault}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) gen(mkp(0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0, -1));
    gen(mkp(0, 1'b0, 4, 1'b0, 1'b0, 0, 1'b0, 32'h0, -1));        // 6-cycle EX stall
    gen(mkp(1, 1'b1, 0, 1'b1, 1'b0, 3, 1'b0, 32'h0, -1));        // load, 4 MEM cycles
    gen(mkp(0, 1'b1, 1, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0103, -1));
    gen(mkp(0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, -1));
    gen(mkp(0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0, -1));        // wraps pc to 0
    gen(mkp(0, 1'b1, 2, 1'b0, 1'b0, 0, 1'b0, 32'h0, 2));         // halt pulse in first EX
    gen(mkp(0, 1'b0, 0, 1'b0, 1'b1, 0, 1'b0, 32'h0, -1));        // store, dmem_ready at once
    run_n(q.size());
    chk("pc_after_directed", pc, 32'd8);
    chk("retired_after_directed", retired, 32'd10);

    for (int n = 0; n < 60; n++) begin
      p.if_w = int'($urandom_range(0, 3)); p.ex0 = 1'($urandom);
      p.ex_s = int'($urandom_range(0, 5)); sel = int'($urandom_range(0, 2));
      p.mrd = (sel == 1); p.mwr = (sel == 2); p.dm_w = int'($urandom_range(0, 4));
      p.br = ($urandom_range(0, 3) == 0); p.ba = $urandom;
      p.halt_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 30)) : -1;
      gen(p);
      run_n(q.size());
    end

    // reset while a load is waiting in MEM
    gen(mkp(0, 1'b1, 0, 1'b1, 1'b0, 10, 1'b0, 32'h0, -1));
    idx = 0;
    while (q[idx].st != ST_MEM) idx++;
    run_n(idx + 2);
    q.delete();
    rst = 1'b1; ex_mem_read = 1'b1; dmem_ready = 1'b0;
    @(posedge clk); #1;
    chk("midmem_state", 32'(state), 32'(ST_IDLE));
    chk("midmem_pc", pc, RST_PC);
    chk("midmem_retired", retired, 32'd0);
    chk("midmem_dmem_req", 32'(dmem_req), 32'd0);
    chk("midmem_wb_en", 32'(wb_en), 32'd0);
    rst = 1'b0;
    m_pc = RST_PC; m_ret = '0; m_idle = 1'b1;

`ifdef CORE_SEQ_EX_TIMEOUT_EN
    gen(mkp(0, 1'b0, 20, 1'b0, 1'b0, 0, 1'b0, 32'h0, -1));
    idx = 0;
    while (q[idx].st != ST_EX) idx++;
    run_n(idx + 8);
    q.delete();
    ex_data_ready = 1'b0; start = 1'b0; halt_req = 1'b0;
    @(negedge clk);
    chk("tmo_state", 32'(state), 32'(ST_IDLE));
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_retired", retired, 32'd0);
    chk("tmo_pc", pc, RST_PC);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("tmo_start_ignored", 32'(state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("tmo_fault_cleared", 32'(fault), 32'd0);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
